// File: rtl/adder_rca_unit.sv
// rtl/adder_rca_unit.sv - registered ripple-carry adder built from a full-adder chain

// One-bit full adder cell; the unit of the ripple chain.
module adder_rca_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic p;

  // Propagate term is shared between sum and carry so the carry uses the
  // (c & (a ^ b)) form rather than a majority gate.
  assign p   = a_i ^ b_i;
  assign s_o = p ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & p);

endmodule

// Top: w-bit ripple chain feeding one output register stage.
module adder_rca_unit #(
  parameter int w = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [w-1:0] x,
  input  logic [w-1:0] y,
  input  logic         carry_in,
  output logic [w-1:0] sum,
  output logic         carry_out
);

  // c[0] is the incoming carry, c[w] leaves the top bit.
  logic [w:0]   c;
  logic [w-1:0] sum_d;
  logic         carry_out_d;
  logic [w-1:0] sum_q;
  logic         carry_out_q;

  assign c[0] = carry_in;

  // Structural chain: each cell consumes the carry of the cell below it,
  // so the critical path runs c[0] through c[w] with no lookahead.
  for (genvar i = 0; i < w; i++) begin : g_chain
    adder_rca_fa u_fa (
      .a_i (x[i]),
      .b_i (y[i]),
      .c_i (c[i]),
      .s_o (sum_d[i]),
      .c_o (c[i+1])
    );
  end

  assign carry_out_d = c[w];

  // Capture the result every edge; reset clears immediately and drops any
  // in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      carry_out_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
    end
  end

  assign sum       = sum_q;
  assign carry_out = carry_out_q;

endmodule

// File: tb/tb_adder_rca_unit.sv
// tb/tb_adder_rca_unit.sv - scoreboard bench for adder_rca_unit at w = 9, 1 and 16
module tb_adder_rca_unit;

  logic        clk;
  logic        rst_n;
  logic [63:0] x_all;
  logic [63:0] y_all;
  logic        cin;

  logic [8:0]  sum9;
  logic        co9;
  logic [0:0]  sum1;
  logic        co1;
  logic [15:0] sum16;
  logic        co16;

  int checks;
  int errors;

  logic [9:0]  q9[$];
  logic [1:0]  q1[$];
  logic [16:0] q16[$];

  adder_rca_unit #(.w(9)) u_dut9 (
    .clk       (clk),
    .rst_n     (rst_n),
    .x         (x_all[8:0]),
    .y         (y_all[8:0]),
    .carry_in  (cin),
    .sum       (sum9),
    .carry_out (co9)
  );

  adder_rca_unit #(.w(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .x         (x_all[0:0]),
    .y         (y_all[0:0]),
    .carry_in  (cin),
    .sum       (sum1),
    .carry_out (co1)
  );

  adder_rca_unit #(.w(16)) u_dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .x         (x_all[15:0]),
    .y         (y_all[15:0]),
    .carry_in  (cin),
    .sum       (sum16),
    .carry_out (co16)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one vector at the falling edge, record expected results, then
  // compare just after the next rising edge.
  task automatic apply(input string tag, input logic [63:0] xa, input logic [63:0] ya, input logic ci);
    logic [9:0]  e9;
    logic [1:0]  e1;
    logic [16:0] e16;
    @(negedge clk);
    x_all = xa;
    y_all = ya;
    cin   = ci;
    q9.push_back({1'b0, xa[8:0]} + {1'b0, ya[8:0]} + {9'd0, ci});
    q1.push_back({1'b0, xa[0]} + {1'b0, ya[0]} + {1'b0, ci});
    q16.push_back({1'b0, xa[15:0]} + {1'b0, ya[15:0]} + {16'd0, ci});
    @(posedge clk);
    #1;
    check_eq({tag, "_sb_level"}, 64'(q9.size()), 64'd1);
    if (q9.size() != 0) begin
      e9  = q9.pop_front();
      e1  = q1.pop_front();
      e16 = q16.pop_front();
      check_eq({tag, "_w9"},  64'({co9, sum9}),   64'(e9));
      check_eq({tag, "_w1"},  64'({co1, sum1}),   64'(e1));
      check_eq({tag, "_w16"}, 64'({co16, sum16}), 64'(e16));
    end
  endtask

  initial begin
    clk    = 1'b0;
    rst_n  = 1'b1;
    x_all  = '0;
    y_all  = '0;
    cin    = 1'b0;
    checks = 0;
    errors = 0;

    #1 rst_n = 1'b0;
    #2;
    check_eq("reset_sum9", 64'(sum9), 64'd0);
    check_eq("reset_co9",  64'(co9),  64'd0);
    check_eq("reset_w16",  64'({co16, sum16}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    apply("small_3p2",   64'd3,   64'd2,   1'b0);
    apply("small_1p1",   64'd1,   64'd1,   1'b0);
    apply("wrap_511p1",  64'd511, 64'd1,   1'b0);
    apply("wrap_511p1c", 64'd511, 64'd1,   1'b1);
    apply("ripple",      64'd341, 64'd170, 1'b0);
    apply("ripple_c",    64'd341, 64'd170, 1'b1);
    apply("cin_5p3",     64'd5,   64'd3,   1'b1);
    apply("cin_0p1",     64'd0,   64'd1,   1'b1);

    // Outputs hold while inputs move between edges.
    x_all = 64'd7;
    y_all = 64'd9;
    #2;
    check_eq("hold_w9", 64'({co9, sum9}), 64'd2);

    // Reset mid-operation.
    apply("rst_load", 64'd511, 64'd511, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_async_w9", 64'({co9, sum9}), 64'd0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      check_eq("rst_held_w9", 64'({co9, sum9}), 64'd0);
    end
    @(negedge clk);
    x_all = 64'd100;
    y_all = 64'd27;
    cin   = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_release_w9", 64'({co9, sum9}), 64'd127);

    // Back-to-back random sweep.
    for (int i = 0; i < 1200; i++) begin
      apply("rand", {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
